// File: rtl/arbiter_rr4.sv
// arbiter_rr4 -- four-way round-robin arbiter with a bounded grant hold time.
//
// A single owner is granted at a time. The grant ends when the owner signals
// it is finished, drops its request, or has held the grant for MAX_HOLD
// cycles. In the last case a one-cycle timeout pulse follows. After every
// grant the search pointer moves to the requester just past the previous
// owner, so a requester that re-asserts waits behind everyone else pending.
//
// Parameters
//   MAX_HOLD   maximum consecutive cycles a grant is held (2..255)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[3:0]   request lines, bit i = requester i
//   rls        release: the current owner is finished; only looked at
//              while a grant is live (the word "release" is reserved in
//              SystemVerilog, hence the short name)
//   gnt_idx    binary index of the granted requester (feeds a 2-to-4 decoder)
//   gnt_valid  gnt_idx is a live grant
//   timeout    one-cycle pulse after a grant is revoked by the hold limit

module arbiter_rr4 #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       rls,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] hold_cnt;
  logic [1:0] pick;
  logic       hold_hit;
  logic       owner_drop;
  logic       grant_exit;

  // Rotating priority search. The loop walks from the lowest priority offset
  // (ptr+3) down to ptr, so the last hit written is the highest-priority
  // requester. When nothing is requesting, pick is unused.
  always_comb begin
    pick = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        pick = ptr + 2'(i);
      end
    end
  end

  // Grant exit reasons. A timeout is reported only when the hold limit is the
  // sole reason; a release or dropped request on the same edge counts as a
  // normal exit.
  assign hold_hit   = (hold_cnt == HOLD_LAST);
  assign owner_drop = ~req[gnt_idx];
  assign grant_exit = rls | owner_drop | hold_hit;

  // Two-state grant FSM with all outputs registered. Leaving GRANT always
  // passes through IDLE for at least one cycle, which guarantees the low gap
  // on gnt_valid between consecutive grants and clears the timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      hold_cnt  <= 8'd0;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_idx   <= pick;
            gnt_valid <= 1'b1;
            hold_cnt  <= 8'd0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (grant_exit) begin
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 2'd1;
            timeout   <= hold_hit & ~rls & ~owner_drop;
            state     <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_rr4.sv
// tb_arbiter_rr4 -- bench for arbiter_rr4 built with MAX_HOLD = 4.
//
// The stimulus process drives directed request/release patterns and, as it
// issues each one, queues the grant it should produce: owner index, number of
// cycles gnt_valid stays high, and whether a timeout pulse follows. A monitor
// process watches the outputs on every falling clock edge, measures each grant
// as it happens and compares it against the head of the queue when the grant
// ends (or is aborted by reset).

module tb_arbiter_rr4;

  localparam int MAX_HOLD = 4;

  typedef struct {
    logic [1:0] idx;
    int         len;
    logic       to;
  } grant_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       rls;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int         checks;
  int         failures;
  grant_t     sb[$];

  logic       in_grant;
  logic [1:0] cur_idx;
  int         cur_len;

  arbiter_rr4 #(
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .rls      (rls),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, changed on the falling edge so the DUT sees
  // them stable at the next rising edge.
  task automatic applyStimulus(input logic [3:0] r, input logic rl);
    @(negedge clk);
    req = r;
    rls = rl;
  endtask

  task automatic expectGrant(input logic [1:0] idx, input int len, input logic to);
    grant_t g;
    g.idx = idx;
    g.len = len;
    g.to  = to;
    sb.push_back(g);
  endtask

  // Compare a finished grant against the oldest expected one.
  task automatic closeGrant(input logic to_seen);
    grant_t g;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_grant: got idx %0d len %0d, expected none", cur_idx, cur_len);
    end else begin
      g = sb.pop_front();
      checkOutput("grant_idx", 32'(cur_idx), 32'(g.idx));
      checkOutput("grant_len", 32'(cur_len), 32'(g.len));
      checkOutput("grant_timeout", 32'(to_seen), 32'(g.to));
    end
    in_grant = 1'b0;
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    in_grant = 1'b0;
    cur_idx  = 2'd0;
    cur_len  = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        if (in_grant) begin
          closeGrant(timeout);
        end
      end else if (gnt_valid === 1'b1) begin
        if (!in_grant) begin
          in_grant = 1'b1;
          cur_idx  = gnt_idx;
          cur_len  = 1;
        end else begin
          cur_len++;
          checkOutput("idx_stable", 32'(gnt_idx), 32'(cur_idx));
        end
        checkOutput("no_timeout_in_grant", 32'(timeout), 32'd0);
      end else if (in_grant) begin
        closeGrant(timeout);
      end else begin
        checkOutput("no_timeout_idle", 32'(timeout), 32'd0);
      end
    end
  end

  // Stimulus with hand-computed expectations (MAX_HOLD = 4).
  initial begin
    checks   = 0;
    failures = 0;
    req      = 4'b0000;
    rls      = 1'b0;
    rst_n    = 1'b1;

    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_valid", 32'(gnt_valid), 32'd0);
    checkOutput("reset_idx", 32'(gnt_idx), 32'd0);
    checkOutput("reset_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    @(negedge clk);

    // First request straight out of reset, granted one edge later.
    rst_n = 1'b1;
    req   = 4'b0100;
    rls   = 1'b0;
    expectGrant(2'd2, 1, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("first_valid", 32'(gnt_valid), 32'd1);
    checkOutput("first_idx", 32'(gnt_idx), 32'd2);
    checkOutput("first_decode", 32'(4'b0001 << gnt_idx), 32'h4);
    applyStimulus(4'b0000, 1'b0);

    // Pointer is now 3: a grant to 3 brings it back to 0.
    expectGrant(2'd3, 1, 1'b0);
    applyStimulus(4'b1000, 1'b0);
    applyStimulus(4'b1000, 1'b1);
    applyStimulus(4'b0000, 1'b0);

    // All requesting, one release per grant: strict rotation 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      expectGrant(2'(k), 1, 1'b0);
      applyStimulus(4'b1111, 1'b0);
      applyStimulus(4'b1111, 1'b1);
    end
    applyStimulus(4'b0000, 1'b0);

    // Single requester holding on: two hold-limit timeouts back to back.
    expectGrant(2'd0, 4, 1'b1);
    expectGrant(2'd0, 4, 1'b1);
    applyStimulus(4'b0001, 1'b0);
    repeat (9) @(negedge clk);
    applyStimulus(4'b0000, 1'b0);

    // Grant to 1, owner drops its request, then 0 is served.
    expectGrant(2'd1, 2, 1'b0);
    expectGrant(2'd0, 1, 1'b0);
    applyStimulus(4'b0011, 1'b0);
    applyStimulus(4'b0011, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b0000, 1'b0);

    // Release while idle does nothing.
    applyStimulus(4'b0000, 1'b1);

    // Release lands on the same edge as the hold limit: normal exit.
    expectGrant(2'd2, 4, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    applyStimulus(4'b0000, 1'b0);

    // Reset between edges during a grant to 3 aborts it immediately.
    expectGrant(2'd3, 2, 1'b0);
    applyStimulus(4'b1000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(gnt_valid), 32'd0);
    checkOutput("abort_idx", 32'(gnt_idx), 32'd0);
    checkOutput("abort_timeout", 32'(timeout), 32'd0);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1000;
    expectGrant(2'd3, 1, 1'b0);
    applyStimulus(4'b1000, 1'b1);
    checkOutput("post_reset_valid", 32'(gnt_valid), 32'd1);
    checkOutput("post_reset_idx", 32'(gnt_idx), 32'd3);
    applyStimulus(4'b0000, 1'b0);

    // Let the monitor retire everything, within a bounded wait.
    for (int w = 0; w < 20 && (sb.size() != 0 || in_grant); w++) begin
      @(negedge clk);
    end
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    checkOutput("grant_closed", 32'(in_grant), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case something wedges the stimulus process.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected end before 50000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
